// File: rtl/commit_trace_buffer_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the commit trace buffer:
//   - field widths and bit offsets of the packed retire record (REC_W = 87)
//   - rec_t, a packed struct whose MSB-first layout is exactly out_rec
//   - state_e, the capture FSM encoding (RUN / DRAIN / DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package trace_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;
  localparam int REG_W  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // Bit offsets inside out_rec, LSB side first.
  localparam int HALT_BIT      = 0;
  localparam int MEM_DATA_LSB  = 1;
  localparam int MEM_ADDR_LSB  = 17;
  localparam int MEM_WRITE_BIT = 33;
  localparam int MEM_READ_BIT  = 34;
  localparam int WR_DATA_LSB   = 35;
  localparam int WR_REG_LSB    = 51;
  localparam int REG_WRITE_BIT = 54;
  localparam int INST_LSB      = 55;
  localparam int PC_LSB        = 71;
  localparam int REC_W         = 87;

  // Member order matches the bit offsets above (first member = MSBs).
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              reg_write;
    logic [REG_W-1:0]  wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              halt;
  } rec_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer_if
// Groups the retire-side inputs and the record output stream of the trace
// buffer.
//   retire side : retire_valid, ret_* fields, stall
//   output side : out_valid, out_ready, out_rec, out_inum
// Modports:
//   master : the trace buffer itself (drives stall and the out_* stream)
//   slave  : the environment (commit stage and host/debug consumer)
//
// Handshake: a record transfers on out_rec/out_inum in any cycle where
// out_valid & out_ready are both 1 at the rising clock edge. While out_valid
// is 1 and out_ready is 0 the head record is held stable. out_valid does not
// depend on out_ready. On the retire side there is no ready; the commit stage
// must hold commit while stall=1, and a retire offered while the buffer cannot
// take it is dropped and flagged as overflow.
// -----------------------------------------------------------------------------
interface commit_trace_buffer_if #(
  parameter int CNT_W = 32
);
  import trace_pkg::*;

  logic              retire_valid;
  logic [PC_W-1:0]   ret_pc;
  logic [INST_W-1:0] ret_inst;
  logic              ret_reg_write;
  logic [REG_W-1:0]  ret_wr_reg;
  logic [DATA_W-1:0] ret_wr_data;
  logic              ret_mem_read;
  logic              ret_mem_write;
  logic [ADDR_W-1:0] ret_mem_addr;
  logic [DATA_W-1:0] ret_mem_data;
  logic              ret_halt;
  logic              stall;

  logic              out_valid;
  logic              out_ready;
  logic [REC_W-1:0]  out_rec;
  logic [CNT_W-1:0]  out_inum;

  modport master (
    input  retire_valid, ret_pc, ret_inst, ret_reg_write, ret_wr_reg,
           ret_wr_data, ret_mem_read, ret_mem_write, ret_mem_addr,
           ret_mem_data, ret_halt, out_ready,
    output stall, out_valid, out_rec, out_inum
  );

  modport slave (
    output retire_valid, ret_pc, ret_inst, ret_reg_write, ret_wr_reg,
           ret_wr_data, ret_mem_read, ret_mem_write, ret_mem_addr,
           ret_mem_data, ret_halt, out_ready,
    input  stall, out_valid, out_rec, out_inum
  );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata_o whenever empty_o=0. A push and a pop in the same cycle are allowed
// even when full (occupancy unchanged).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset (empties the FIFO)
//   push_i       : write wdata_i this cycle
//   pop_i        : discard the head entry this cycle
//   wdata_i      : entry to write
//   rdata_o      : head entry (valid while empty_o=0)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   count_o      : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are never observable because the
  // read side is qualified by empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
// Retire-trace capture stage behind the commit point. Every accepted retire is
// stamped with an instruction number, buffered in a FWFT FIFO and drained to a
// host/debug consumer, giving the same per-instruction view as the simulator
// trace.
// Ports:
//   clk, rst     : core clock, asynchronous active-low reset
//   bus          : retire inputs + stall, and the out_valid/out_ready record
//                  stream (out_rec, out_inum)
//   overflow     : sticky, a retire was offered in RUN but not accepted
//   sim_cycles   : RUN cycles since reset release, including halt-accept
//   inst_count   : records accepted so far
//   done         : halt accepted and every record drained
//   state_dbg_o  : current FSM state
// -----------------------------------------------------------------------------
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  commit_trace_buffer_if.master  bus,
  output logic                   overflow,
  output logic [CNT_W-1:0]       sim_cycles,
  output logic [CNT_W-1:0]       inst_count,
  output logic                   done,
  output state_e                 state_dbg_o
);
  localparam int AW     = $clog2(DEPTH);
  localparam int FIFO_W = REC_W + CNT_W;

  state_e            state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  sim_cycles_q, sim_cycles_d;
  logic [CNT_W-1:0]  inst_count_q, inst_count_d;

  logic              in_run;
  logic              out_valid;
  logic              pop;
  logic              accept;

  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  rec_t              rec_in;

  // ---------------------------------------------------------------------------
  // Record assembly: the inum stamp is the count before this accept.
  // ---------------------------------------------------------------------------
  always_comb begin
    rec_in.pc        = bus.ret_pc;
    rec_in.inst      = bus.ret_inst;
    rec_in.reg_write = bus.ret_reg_write;
    rec_in.wr_reg    = bus.ret_wr_reg;
    rec_in.wr_data   = bus.ret_wr_data;
    rec_in.mem_read  = bus.ret_mem_read;
    rec_in.mem_write = bus.ret_mem_write;
    rec_in.mem_addr  = bus.ret_mem_addr;
    rec_in.mem_data  = bus.ret_mem_data;
    rec_in.halt      = bus.ret_halt;
  end

  assign fifo_wdata = {rec_in, inst_count_q};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. DRAIN ends on the pop that empties the FIFO, so DONE is
  // visible in the first cycle the FIFO is empty.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && bus.ret_halt) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty || (pop && fifo_count == (AW+1)'(1)))
                  state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and handshake qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    in_run    = (state_q == ST_RUN);
    out_valid = ~fifo_empty & (state_q != ST_DONE);
    pop       = out_valid & bus.out_ready;
    // A full FIFO can still take a retire if the head leaves this cycle.
    accept    = bus.retire_valid & in_run & (~fifo_full | pop);
    done      = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Counters and sticky overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    sim_cycles_d = sim_cycles_q;
    inst_count_d = inst_count_q;
    overflow_d   = overflow_q;
    if (in_run)                             sim_cycles_d = sim_cycles_q + 1'b1;
    if (accept)                             inst_count_d = inst_count_q + 1'b1;
    if (in_run && bus.retire_valid && !accept) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sim_cycles_q <= '0;
      inst_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sim_cycles_q <= sim_cycles_d;
      inst_count_q <= inst_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Record fields are forced to zero whenever no head is offered so
  // that reset and DONE present an all-zero record.
  // ---------------------------------------------------------------------------
  assign bus.stall     = fifo_full;
  assign bus.out_valid = out_valid;
  assign bus.out_rec   = out_valid ? fifo_rdata[FIFO_W-1:CNT_W] : '0;
  assign bus.out_inum  = out_valid ? fifo_rdata[CNT_W-1:0]      : '0;

  assign overflow    = overflow_q;
  assign sim_cycles  = sim_cycles_q;
  assign inst_count  = inst_count_q;
  assign state_dbg_o = state_q;

endmodule
